// File: rtl/xsr_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// xsr_pkg : shared widths, states and helpers for the serial receive shifter.
// Revision: 1.0
// ---------------------------------------------------------------------------
package xsr_pkg;

  localparam int RX_WIDTH = 64;
  localparam int BITS_W   = 6;
  localparam int BAUD_W   = 64;

  typedef enum logic [0:0] {IDLE = 1'b0, BUSY = 1'b1} state_t;
  typedef enum logic [0:0] {ASYNC = 1'b0, CLOCKED = 1'b1} mode_t;

  // A programmed length of 0 selects the full register width.
  function automatic logic [BITS_W:0] frame_len(input logic [BITS_W-1:0] bits);
    return (bits == '0) ? (BITS_W+1)'(RX_WIDTH) : {1'b0, bits};
  endfunction

endpackage
`default_nettype wire

// File: rtl/xsr_rx_shifter_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// xsr_rx_shifter_if : configuration, pin and host-side signals of the shifter.
// Revision: 1.0
// ---------------------------------------------------------------------------
interface xsr_rx_shifter_if;
  import xsr_pkg::*;

  logic [BITS_W-1:0]   bits_i;
  logic [BAUD_W-1:0]   baud_i;
  logic                rxd_i;
  logic                rxc_i;
  logic                rxreg_oe_i;
  logic                idle_o;
  logic [RX_WIDTH-1:0] dat_o;
  logic                sample_to;

  modport master (
    output bits_i, baud_i, rxd_i, rxc_i, rxreg_oe_i,
    input  idle_o, dat_o, sample_to
  );

  modport slave (
    input  bits_i, baud_i, rxd_i, rxc_i, rxreg_oe_i,
    output idle_o, dat_o, sample_to
  );

endinterface
`default_nettype wire

// File: rtl/xsr_sync.sv
`default_nettype none
// ---------------------------------------------------------------------------
// xsr_sync : multi-stage pin synchroniser with a configurable reset level.
// Revision: 1.0
// ---------------------------------------------------------------------------
module xsr_sync #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] r_sync;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_sync <= {STAGES{RESET_VAL}};
    end else begin
      r_sync <= {r_sync[STAGES-2:0], d};
    end
  end

  assign q = r_sync[STAGES-1];

endmodule
`default_nettype wire

// File: rtl/xsr_rx_shifter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// xsr_rx_shifter : UART-style receive shift register, baud-timed or rxc-clocked.
// Revision: 1.0
// ---------------------------------------------------------------------------
module xsr_rx_shifter
  import xsr_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk_i,
  input  logic              reset_i,
  xsr_rx_shifter_if.slave   rx
);

  logic                w_rxd_s;
  logic                w_rxc_s;
  logic                r_rxc_prev;
  logic                w_rise;
  logic                w_sample;
  state_t              r_state,  w_state_nxt;
  mode_t               r_mode,   w_mode_nxt;
  logic [BITS_W:0]     r_cnt,    w_cnt_nxt;
  logic [BITS_W:0]     w_cnt_inc;
  logic [BAUD_W-1:0]   r_timer,  w_timer_nxt;
  logic [RX_WIDTH-1:0] r_shreg,  w_shreg_nxt;

  xsr_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_rxd (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .d       (rx.rxd_i),
    .q       (w_rxd_s)
  );

  xsr_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_rxc (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .d       (rx.rxc_i),
    .q       (w_rxc_s)
  );

  assign w_rise = w_rxc_s & ~r_rxc_prev;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_state    <= IDLE;
      r_mode     <= ASYNC;
      r_cnt      <= '0;
      r_timer    <= '0;
      r_shreg    <= '1;
      r_rxc_prev <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_mode     <= w_mode_nxt;
      r_cnt      <= w_cnt_nxt;
      r_timer    <= w_timer_nxt;
      r_shreg    <= w_shreg_nxt;
      r_rxc_prev <= w_rxc_s;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_mode_nxt  = r_mode;
    w_cnt_nxt   = r_cnt;
    w_timer_nxt = r_timer;
    w_shreg_nxt = r_shreg;
    w_sample    = 1'b0;
    w_cnt_inc   = r_cnt + (BITS_W+1)'(1);

    case (r_state)
      IDLE: begin
        if (w_rise) begin
          w_sample    = 1'b1;
          w_mode_nxt  = CLOCKED;
          w_state_nxt = BUSY;
        end else if (!w_rxd_s) begin
          // Half-bit load lands the first async sample mid-bit.
          w_state_nxt = BUSY;
          w_mode_nxt  = ASYNC;
          w_timer_nxt = rx.baud_i >> 1;
        end
      end
      BUSY: begin
        // Once an rxc edge is seen, the timer stays frozen for this frame.
        if (w_rise) begin
          w_sample   = 1'b1;
          w_mode_nxt = CLOCKED;
        end else if (r_mode == ASYNC) begin
          if (r_timer == '0) begin
            w_sample    = 1'b1;
            w_timer_nxt = rx.baud_i;
          end else begin
            w_timer_nxt = r_timer - BAUD_W'(1);
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase

    if (w_sample) begin
      w_shreg_nxt = {w_rxd_s, r_shreg[RX_WIDTH-1:1]};
      if (w_cnt_inc == frame_len(rx.bits_i)) begin
        w_cnt_nxt   = '0;
        w_state_nxt = IDLE;
      end else begin
        w_cnt_nxt   = w_cnt_inc;
      end
    end
  end

  assign rx.idle_o    = (r_state == IDLE);
  assign rx.dat_o     = rx.rxreg_oe_i ? r_shreg : '0;
  assign rx.sample_to = w_sample;

endmodule
`default_nettype wire

// File: tb/tb_xsr_rx_shifter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_xsr_rx_shifter : directed async, back-to-back, clocked, OE and reset tests.
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_xsr_rx_shifter;

  logic clk = 1'b0;
  logic reset_i = 1'b1;

  int n_asserts = 0;
  int n_fails   = 0;
  int n_samples = 0;
  int s_base;

  logic [63:0] m_shreg = '1;
  logic [63:0] exp_q[$];
  logic [0:10] f1 = 11'b01010000101;
  logic [0:10] f3 = 11'b00110101101;

  xsr_rx_shifter_if bus ();

  xsr_rx_shifter #(.SYNC_STAGES(2)) dut (
    .clk_i   (clk),
    .reset_i (reset_i),
    .rx      (bus.slave)
  );

  always #10 clk = ~clk;

  always @(negedge clk) if (bus.sample_to === 1'b1) n_samples++;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One bit time is 50 clocks; the model value is queued when the bit is driven.
  task automatic drive_bit(input logic b, input logic exp_idle, input string tag);
    bus.rxd_i = b;
    m_shreg   = {b, m_shreg[63:1]};
    exp_q.push_back(m_shreg);
    repeat (50) @(negedge clk);
    check({tag, "_dat"}, bus.dat_o, exp_q.pop_front());
    check({tag, "_idle"}, {63'd0, bus.idle_o}, {63'd0, exp_idle});
  endtask

  task automatic do_reset();
    reset_i    = 1'b1;
    bus.rxd_i  = 1'b1;
    bus.rxc_i  = 1'b0;
    repeat (3) @(negedge clk);
    reset_i    = 1'b0;
    m_shreg    = '1;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    bus.bits_i     = 6'd11;
    bus.baud_i     = 64'd49;
    bus.rxd_i      = 1'b1;
    bus.rxc_i      = 1'b0;
    bus.rxreg_oe_i = 1'b1;
    repeat (3) @(negedge clk);
    reset_i = 1'b0;
    @(negedge clk);
    check("rst_idle", {63'd0, bus.idle_o}, 64'd1);
    check("rst_dat", bus.dat_o, 64'hFFFF_FFFF_FFFF_FFFF);
    check("rst_sample_to", {63'd0, bus.sample_to}, 64'd0);
    repeat (2) @(negedge clk);

    // Async 8O1 frame
    s_base = n_samples;
    for (int k = 0; k < 11; k++) drive_bit(f1[k], (k == 10), "async");
    check("async_last11", {53'd0, bus.dat_o[63:53]}, {53'd0, 11'b10100001010});
    check("async_nsamples", 64'(n_samples - s_base), 64'd11);

    // Back-to-back start straight after the stop bit
    drive_bit(1'b0, 1'b0, "b2b");
    check("b2b_literal", bus.dat_o, {12'b010100001010, {52{1'b1}}});

    // Output enable gates the view but not the shifting
    bus.rxreg_oe_i = 1'b0;
    bus.rxd_i      = 1'b1;
    m_shreg        = {1'b1, m_shreg[63:1]};
    repeat (50) @(negedge clk);
    check("oe_off", bus.dat_o, 64'd0);
    bus.rxreg_oe_i = 1'b1;
    #1;
    check("oe_on", bus.dat_o, m_shreg);

    // Clocked mode
    do_reset();
    s_base = n_samples;
    for (int k = 1; k <= 11; k++) begin
      bus.rxc_i = 1'b1;
      if (k == 1) bus.rxd_i = 1'b0;
      if (k == 11) begin
        @(negedge clk);
        bus.rxd_i = 1'b1;
        repeat (24) @(negedge clk);
      end else begin
        repeat (25) @(negedge clk);
      end
      bus.rxc_i = 1'b0;
      repeat (25) @(negedge clk);
      m_shreg = {1'b0, m_shreg[63:1]};
      exp_q.push_back(m_shreg);
      check("clk_dat", bus.dat_o, exp_q.pop_front());
      check("clk_idle", {63'd0, bus.idle_o}, {63'd0, (k == 11)});
    end
    check("clk_nsamples", 64'(n_samples - s_base), 64'd11);

    // Reset mid-frame, then a fresh frame
    repeat (5) @(negedge clk);
    for (int k = 0; k < 5; k++) drive_bit(f1[k], 1'b0, "pre_rst");
    reset_i = 1'b1;
    #1;
    check("midrst_idle", {63'd0, bus.idle_o}, 64'd1);
    check("midrst_dat", bus.dat_o, 64'hFFFF_FFFF_FFFF_FFFF);
    bus.rxd_i = 1'b1;
    repeat (3) @(negedge clk);
    reset_i = 1'b0;
    m_shreg = '1;
    repeat (3) @(negedge clk);
    for (int k = 0; k < 11; k++) drive_bit(f3[k], (k == 10), "fresh");

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
    $finish;
  end

endmodule
`default_nettype wire
